// File: rtl/frame_switch_mux.sv
// Output-port frame switch: arbiter request/grant, frame lock, 2-entry skid.
// Define FRAME_SWITCH_MUX_TIMEOUT_EN to force-release stalled locks.
module frame_switch_mux #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ-1:0]        in_last,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic [NUM_REQ-1:0]        arb_req,
  input  logic [NUM_REQ-1:0]        arb_grant,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      lock_active,
  output logic                      err_timeout
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("NUM_REQ must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic [DATA_W:0]    fifo_q [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;

  logic               space;
  logic               push;
  logic               pop;
  logic               grant_onehot;
  logic [SEL_W-1:0]   grant_idx;
  logic [SEL_W-1:0]   src;
  logic               src_valid;
  logic               src_last;
  logic [DATA_W-1:0]  src_data;
  logic               timeout_hit;

  assign space = (count != 2'd2);
  assign pop = (count != 2'd0) & out_ready;
  assign grant_onehot = (arb_grant != '0) &&
                        ((arb_grant & (arb_grant - NUM_REQ'(1))) == '0);

  assign out_valid = (count != 2'd0);
  assign {out_last, out_data} = fifo_q[rd_ptr];
  assign lock_active = (state == LOCKED);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) grant_idx = SEL_W'(i);
    end
  end

  // The beat source is the granted channel in IDLE, the locked one otherwise.
  always_comb begin
    src = (state == IDLE) ? grant_idx : sel;
    src_valid = 1'b0;
    src_last = 1'b0;
    src_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (SEL_W'(i) == src) begin
        src_valid = in_valid[i];
        src_last = in_last[i];
        src_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    arb_req = '0;
    in_ready = '0;
    push = 1'b0;
    if (state == IDLE) begin
      if (space) arb_req = in_valid;
      if (space && grant_onehot && src_valid) begin
        in_ready = arb_grant;
        push = 1'b1;
      end
    end else begin
      in_ready[sel] = space;
      push = space & src_valid;
    end
  end

`ifdef FRAME_SWITCH_MUX_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ?
                         $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] idle_cnt;
  logic             err_q;

  assign timeout_hit = (state == LOCKED) && !src_valid &&
                       (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state != LOCKED || push || timeout_hit) idle_cnt <= '0;
      else if (!src_valid) idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= {src_last, src_data};
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      unique case (state)
        IDLE: begin
          if (push) begin
            sel <= src;
            if (!src_last) state <= LOCKED;
          end
        end
        LOCKED: begin
          if ((push && src_last) || timeout_hit) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_switch_mux.md
# frame_switch_mux

Per-output-port frame switch stage that sits directly downstream of the round-robin arbiter. It presents the input channels' valid lines to the arbiter as requests and captures the one-hot grant. It locks the selected channel until that channel's last beat and forwards the beats through a 2-entry output skid buffer with a valid/ready handshake. The lock keeps frames atomic, so beats from different inputs never interleave on an output port.

## Interface
- NUM_REQ, 4: number of input channels (≥2).
- DATA_W, 64: frame beat width.
- TIMEOUT_CYC, 255: idle-beat limit while locked; used only with the timeout feature (≥1).

Ports (clock and reset first):
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low; clock clk.
- in_valid  in  NUM_REQ  per-channel beat valid.
- in_last  in  NUM_REQ  per-channel last-beat flag.
- in_data  in  NUM_REQ*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_REQ  per-channel accept.
- arb_req  out  NUM_REQ  request vector to the arbiter.
- arb_grant  in  NUM_REQ  one-hot, combinational grant from the arbiter.
- out_valid  out  1  output beat valid.
- out_last  out  1  output last flag.
- out_data  out  DATA_W  output beat.
- out_ready  in  1  downstream accept.
- lock_active  out  1  a frame is in progress.
- err_timeout  out  1  one-cycle pulse when a lock is force-released.

## Operation
- Input transfer on channel i: in_valid[i] & in_ready[i]. Output transfer: out_valid & out_ready.
- Skid buffer: 2 entries, each holding {last, data}. `space` = at least one entry free.
- State machine, IDLE / LOCKED:
  - IDLE:
    - arb_req = in_valid when `space`, else all-zero. Requests are withheld so the arbiter pointer only advances when a beat can actually move.
    - If arb_grant is one-hot and the granted channel is valid:
      - in_ready = arb_grant.
      - The beat is written into the buffer and sel ← index.
      - If the beat is not last, go to LOCKED.
      - A single-beat frame (last on the first beat) stays in IDLE.
    - A zero, multi-hot, or non-valid grant: no transfer, in_ready = 0.
  - LOCKED:
    - arb_req = 0.
    - in_ready[sel] = `space`; all other bits of in_ready are 0.
    - Each accepted beat is written into the buffer.
    - An accepted beat with in_last[sel] = 1 returns to IDLE.
- The buffer is FIFO ordered. out_valid = buffer not empty. out_data and out_last come from the head entry.
- lock_active = (state == LOCKED).
- Buffer counter width: 2 bits. Simultaneous push and pop leaves the count unchanged. No push occurs when the buffer is full; no pop occurs when it is empty.

## Timing
- Reset values:
  - state = IDLE, buffer empty, sel = 0, timeout counter = 0.
  - out_valid = 0, out_last = 0, out_data = 0.
  - in_ready = 0, arb_req = 0, lock_active = 0, err_timeout = 0.
- in_ready and arb_req are combinational from registered state and in_valid / arb_grant. No input→output combinational path exists on out_*.
- Latency: an accepted beat appears on out_* the next cycle.
- Throughput: 1 beat per cycle while out_ready = 1.
- After a last beat, the next arbitration happens in the following cycle (IDLE). The gap between frames is 0 bubbles on the output when the buffer already holds data.
- out_valid held with out_ready = 0: out_data and out_last stay stable. Up to 2 beats are absorbed, then in_ready drops.
- Reset asserted mid-frame: the lock is dropped and buffered beats are discarded. The upstream source must also be reset.
- in_valid deasserting while locked: the lock is held, with no time limit unless the timeout feature is compiled in.

## Configuration
- FRAME_SWITCH_MUX_TIMEOUT_EN defined:
  - In LOCKED, an 8-bit or wider counter increments each cycle in which in_valid[sel] = 0, and clears on any accepted beat.
  - When the count reaches TIMEOUT_CYC: err_timeout pulses for 1 cycle, state → IDLE, counter → 0. Beats already buffered are still delivered.
- Macro undefined: no counter is present, err_timeout is tied to 0, and the lock is held until the last beat.

## Test plan
- Single frame: ch1 sends 3 beats (last on the 3rd), out_ready = 1, grant = 0010 → out shows the 3 beats on consecutive cycles starting 1 cycle later, out_last only on beat 3, lock_active high for 2 cycles.
- Contention: ch0 and ch2 both valid with 2-beat frames; grant 0001 then 0100 → ch0's frame is fully output before any ch2 beat; arb_req = 0 while locked.
- Backpressure: out_ready = 0 during a 4-beat frame → exactly 2 beats accepted, then in_ready[sel] = 0 and out_data stable; on release all 4 beats are delivered in order.
- Single-beat frames back-to-back from ch3 (last = 1 each) → state never leaves IDLE, one arb_req per beat, 1 beat per cycle output.
- Reset mid-frame: rst_n low for 1 cycle after beat 2 of 4 → next cycle out_valid = 0, state IDLE, new grant accepted.
- With FRAME_SWITCH_MUX_TIMEOUT_EN and TIMEOUT_CYC = 8: ch0 sends 1 non-last beat then stalls → err_timeout pulses after 8 idle cycles, lock_active falls, ch1 gets granted next.
